// File: rtl/ws_mac_pe_pkg.sv
// ws_mac_pe_pkg: shared widths, weight-buffer state encoding and accumulator clamp helpers
package ws_mac_pe_pkg;
  localparam int DEF_I_F_BW = 8;
  localparam int DEF_W_BW   = 8;
  localparam int DEF_M_BW   = 16;
  localparam int DEF_ACC_BW = 24;
  // Encoding is {shadow_vld, active_vld} so the two valid bits read straight off the state.
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    ACTIVE = 2'b01,
    SHADOW = 2'b10,
    BOTH   = 2'b11
  } w_state_e;
  function automatic logic [63:0] acc_max(input int bw, input logic sgn);
    return sgn ? (64'd1 << (bw - 1)) - 64'd1 : (64'd1 << bw) - 64'd1;
  endfunction
  function automatic logic [63:0] acc_min(input int bw, input logic sgn);
    return sgn ? (64'd1 << (bw - 1)) : 64'd0;
  endfunction
endpackage

// File: rtl/ws_mac_pe_if.sv
// ws_mac_pe_if: control, operand and result bundle of one weight-stationary PE
//  master: array/test side (drives i_* and controls), slave: the PE (drives o_*)
//  controls: pe_en, signed_mode, acc_mode, w_swap, acc_clr, acc_drain
//  west/north in: i_fmap(+vld), i_weight(+vld), i_psum; east/south out: o_fmap, o_weight, o_psum, o_ovf
interface ws_mac_pe_if
  import ws_mac_pe_pkg::*;
#(
  parameter int I_F_BW = DEF_I_F_BW,
  parameter int W_BW   = DEF_W_BW,
  parameter int ACC_BW = DEF_ACC_BW
) ();
  logic              pe_en;
  logic              signed_mode;
  logic              acc_mode;
  logic [I_F_BW-1:0] i_fmap;
  logic              i_fmap_vld;
  logic [W_BW-1:0]   i_weight;
  logic              i_weight_vld;
  logic              w_swap;
  logic [ACC_BW-1:0] i_psum;
  logic              acc_clr;
  logic              acc_drain;
  logic [I_F_BW-1:0] o_fmap;
  logic              o_fmap_vld;
  logic [W_BW-1:0]   o_weight;
  logic              o_weight_vld;
  logic [ACC_BW-1:0] o_psum;
  logic              o_psum_vld;
  logic              o_ovf;
  modport master (
    output pe_en, signed_mode, acc_mode, i_fmap, i_fmap_vld, i_weight, i_weight_vld,
           w_swap, i_psum, acc_clr, acc_drain,
    input  o_fmap, o_fmap_vld, o_weight, o_weight_vld, o_psum, o_psum_vld, o_ovf
  );
  modport slave (
    input  pe_en, signed_mode, acc_mode, i_fmap, i_fmap_vld, i_weight, i_weight_vld,
           w_swap, i_psum, acc_clr, acc_drain,
    output o_fmap, o_fmap_vld, o_weight, o_weight_vld, o_psum, o_psum_vld, o_ovf
  );
endinterface

// File: rtl/ws_mac_pe_mul.sv
// ws_mac_pe_mul: combinational fmap x weight multiplier, signed or unsigned per signed_i
//  a_i fmap, b_i weight, signed_i operand interpretation, prod_o M_BW-bit product
module ws_mac_pe_mul
  import ws_mac_pe_pkg::*;
#(
  parameter int I_F_BW = DEF_I_F_BW,
  parameter int W_BW   = DEF_W_BW,
  parameter int M_BW   = DEF_M_BW
) (
  input  logic [I_F_BW-1:0] a_i,
  input  logic [W_BW-1:0]   b_i,
  input  logic              signed_i,
  output logic [M_BW-1:0]   prod_o
);
  logic [M_BW-1:0] a_ext, b_ext;
  // The low M_BW bits of a product of sign-extended operands are the signed product,
  // so one unsigned multiplier covers both modes.
  assign a_ext  = {{W_BW{signed_i & a_i[I_F_BW-1]}}, a_i};
  assign b_ext  = {{I_F_BW{signed_i & b_i[W_BW-1]}}, b_i};
  assign prod_o = a_ext * b_ext;
endmodule

// File: rtl/ws_mac_pe.sv
// ws_mac_pe: weight-stationary MAC PE with double-buffered weights, chain or local accumulate
//  clk, rst_n (async active-low), pe_if (slave modport of ws_mac_pe_if)
//  Build option ACC_SAT_EN: overflowing adds clamp to the ACC_BW range instead of wrapping.
module ws_mac_pe
  import ws_mac_pe_pkg::*;
#(
  parameter int I_F_BW = DEF_I_F_BW,
  parameter int W_BW   = DEF_W_BW,
  parameter int M_BW   = DEF_M_BW,
  parameter int ACC_BW = DEF_ACC_BW
) (
  input logic       clk,
  input logic       rst_n,
  ws_mac_pe_if.slave pe_if
);
  logic [I_F_BW-1:0] fmap_q, fmap_d;
  logic              fmap_vld_q;
  logic [W_BW-1:0]   weight_q, weight_d;
  logic              weight_vld_q;
  logic [W_BW-1:0]   shadow_q, shadow_d, active_q, active_d;
  w_state_e          state_q, state_d;
  logic [ACC_BW-1:0] acc_q, acc_d, psum_q, psum_d;
  logic              psum_vld_q, psum_vld_d;
  logic              ovf_q, ovf_d;
  logic              sh_vld, act_vld, swap, add_en, ovf;
  logic [M_BW-1:0]   mul_p, prod;
  logic [ACC_BW-1:0] ext, add_a, add_b, res;
  logic [ACC_BW:0]   sum;
  assign {sh_vld, act_vld} = state_q;
  ws_mac_pe_mul #(.I_F_BW(I_F_BW), .W_BW(W_BW), .M_BW(M_BW)) u_mul (
    .a_i      (pe_if.i_fmap),
    .b_i      (active_q),
    .signed_i (pe_if.signed_mode),
    .prod_o   (mul_p)
  );
  assign prod  = act_vld ? mul_p : '0;
  assign ext   = {{(ACC_BW-M_BW){pe_if.signed_mode & prod[M_BW-1]}}, prod};
  // One adder serves both modes: north psum in chain mode, the accumulator in local mode.
  assign add_a = pe_if.acc_mode ? acc_q : pe_if.i_psum;
  assign add_b = pe_if.i_fmap_vld ? ext : '0;
  assign sum   = {1'b0, add_a} + {1'b0, add_b};
  assign ovf   = pe_if.signed_mode
               ? (add_a[ACC_BW-1] == add_b[ACC_BW-1]) && (sum[ACC_BW-1] != add_a[ACC_BW-1])
               : sum[ACC_BW];
`ifdef ACC_SAT_EN
  // Unsigned adds can only overflow upward; signed overflow direction follows the operand sign.
  assign res = !ovf ? sum[ACC_BW-1:0]
             : (pe_if.signed_mode & add_a[ACC_BW-1]) ? ACC_BW'(acc_min(ACC_BW, 1'b1))
             : ACC_BW'(acc_max(ACC_BW, pe_if.signed_mode));
`else
  assign res = sum[ACC_BW-1:0];
`endif
  always_comb begin
    fmap_d     = pe_if.i_fmap_vld ? pe_if.i_fmap : fmap_q;
    weight_d   = pe_if.i_weight_vld ? pe_if.i_weight : weight_q;
    swap       = pe_if.w_swap & sh_vld;
    active_d   = swap ? shadow_q : active_q;
    shadow_d   = pe_if.i_weight_vld ? pe_if.i_weight : shadow_q;
    state_d    = w_state_e'({pe_if.i_weight_vld | (sh_vld & ~pe_if.w_swap), act_vld | swap});
    add_en     = pe_if.acc_mode ? pe_if.acc_drain | (pe_if.i_fmap_vld & ~pe_if.acc_clr)
                                : pe_if.i_fmap_vld;
    psum_vld_d = pe_if.acc_mode ? pe_if.acc_drain : pe_if.i_fmap_vld;
    psum_d     = psum_vld_d ? res : psum_q;
    acc_d      = (pe_if.acc_clr | (pe_if.acc_mode & pe_if.acc_drain)) ? '0
               : (pe_if.acc_mode & pe_if.i_fmap_vld) ? res : acc_q;
    ovf_d      = (ovf_q & ~pe_if.acc_clr) | (add_en & ovf);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmap_q       <= '0;
      fmap_vld_q   <= 1'b0;
      weight_q     <= '0;
      weight_vld_q <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
      state_q      <= EMPTY;
      acc_q        <= '0;
      psum_q       <= '0;
      psum_vld_q   <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (pe_if.pe_en) begin
      fmap_q       <= fmap_d;
      fmap_vld_q   <= pe_if.i_fmap_vld;
      weight_q     <= weight_d;
      weight_vld_q <= pe_if.i_weight_vld;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      state_q      <= state_d;
      acc_q        <= acc_d;
      psum_q       <= psum_d;
      psum_vld_q   <= psum_vld_d;
      ovf_q        <= ovf_d;
    end
  end
  assign pe_if.o_fmap       = fmap_q;
  assign pe_if.o_fmap_vld   = fmap_vld_q;
  assign pe_if.o_weight     = weight_q;
  assign pe_if.o_weight_vld = weight_vld_q;
  assign pe_if.o_psum       = psum_q;
  assign pe_if.o_psum_vld   = psum_vld_q;
  assign pe_if.o_ovf        = ovf_q;
endmodule

// File: tb/tb_ws_mac_pe.sv
// tb_ws_mac_pe: directed and randomized checks of ws_mac_pe against an integer-arithmetic reference
module tb_ws_mac_pe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ws_mac_pe_if pe_if ();
  ws_mac_pe dut (.clk(clk), .rst_n(rst_n), .pe_if(pe_if));
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  m_shadow, m_active, m_fmap, m_wt;
  bit          m_sv, m_av, m_fv, m_wv, m_pv, m_ovf;
  logic [23:0] m_acc, m_psum;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic longint val(input logic [23:0] x, input int w, input bit s);
    longint v;
    v = longint'(x) & ((longint'(1) << w) - 1);
    if (s && v[w-1]) v -= longint'(1) << w;
    return v;
  endfunction
  task automatic model_reset();
    m_shadow = 0; m_active = 0; m_fmap = 0; m_wt = 0;
    m_sv = 0; m_av = 0; m_fv = 0; m_wv = 0; m_pv = 0; m_ovf = 0;
    m_acc = 0; m_psum = 0;
  endtask
  // One enabled clock of the PE described as plain arithmetic on integer values.
  task automatic model_step();
    longint p, s, lo, hi;
    logic [23:0] res;
    bit sm, am, ov, did_add;
    sm = pe_if.signed_mode;
    am = pe_if.acc_mode;
    p  = m_av ? val(24'(pe_if.i_fmap), 8, sm) * val(24'(m_active), 8, sm) : 0;
    s  = (am ? val(m_acc, 24, sm) : val(pe_if.i_psum, 24, sm)) + (pe_if.i_fmap_vld ? p : 0);
    lo = sm ? -(longint'(1) << 23) : 0;
    hi = sm ? (longint'(1) << 23) - 1 : (longint'(1) << 24) - 1;
    ov = (s < lo) || (s > hi);
    res = s[23:0];
`ifdef ACC_SAT_EN
    if (ov) res = (s > hi) ? hi[23:0] : lo[23:0];
`endif
    did_add = am ? (pe_if.acc_drain || (pe_if.i_fmap_vld && !pe_if.acc_clr)) : pe_if.i_fmap_vld;
    m_pv = am ? pe_if.acc_drain : pe_if.i_fmap_vld;
    if (m_pv) m_psum = res;
    if (pe_if.acc_clr || (am && pe_if.acc_drain)) m_acc = 0;
    else if (am && pe_if.i_fmap_vld) m_acc = res;
    m_ovf = (m_ovf && !pe_if.acc_clr) || (did_add && ov);
    if (pe_if.w_swap && m_sv) begin m_active = m_shadow; m_av = 1; m_sv = 0; end
    if (pe_if.i_weight_vld) begin m_shadow = pe_if.i_weight; m_sv = 1; end
    m_fv = pe_if.i_fmap_vld;
    if (m_fv) m_fmap = pe_if.i_fmap;
    m_wv = pe_if.i_weight_vld;
    if (m_wv) m_wt = pe_if.i_weight;
  endtask
  task automatic compare_all();
    check("fmap", 64'(pe_if.o_fmap), 64'(m_fmap));
    check("fmap_vld", 64'(pe_if.o_fmap_vld), 64'(m_fv));
    check("weight", 64'(pe_if.o_weight), 64'(m_wt));
    check("weight_vld", 64'(pe_if.o_weight_vld), 64'(m_wv));
    check("psum_vld", 64'(pe_if.o_psum_vld), 64'(m_pv));
    if (m_pv) check("psum", 64'(pe_if.o_psum), 64'(m_psum));
    check("ovf", 64'(pe_if.o_ovf), 64'(m_ovf));
  endtask
  task automatic cyc();
    if (pe_if.pe_en) model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask
  task automatic idle();
    pe_if.pe_en = 1; pe_if.i_fmap = 0; pe_if.i_fmap_vld = 0; pe_if.i_weight = 0;
    pe_if.i_weight_vld = 0; pe_if.w_swap = 0; pe_if.i_psum = 0;
    pe_if.acc_clr = 0; pe_if.acc_drain = 0;
  endtask
  task automatic load_w(input logic [7:0] w);
    idle(); pe_if.i_weight = w; pe_if.i_weight_vld = 1; cyc();
    idle(); pe_if.w_swap = 1; cyc();
    idle();
  endtask
  task automatic reset_now();
    #2 rst_n = 0;
    #1 model_reset();
    compare_all();
    check("rst_psum", 64'(pe_if.o_psum), 64'd0);
    @(negedge clk) rst_n = 1;
  endtask
  logic [43:0] snap;
  initial begin
    idle(); pe_if.signed_mode = 0; pe_if.acc_mode = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("rst_psum", 64'(pe_if.o_psum), 64'd0);
    rst_n = 1;
    // 1: chain, 3*5+10
    load_w(8'd3);
    pe_if.i_fmap = 5; pe_if.i_fmap_vld = 1; pe_if.i_psum = 10; cyc();
    check("t1_psum", 64'(pe_if.o_psum), 64'd25);
    check("t1_vld", 64'(pe_if.o_psum_vld), 64'd1);
    // 2: swap and load in the same cycle
    idle(); pe_if.i_weight = 7; pe_if.i_weight_vld = 1; cyc();
    idle(); pe_if.i_weight = 9; pe_if.i_weight_vld = 1; pe_if.w_swap = 1; cyc();
    idle(); pe_if.i_fmap = 2; pe_if.i_fmap_vld = 1; cyc();
    check("t2_prod7", 64'(pe_if.o_psum), 64'd14);
    idle(); pe_if.w_swap = 1; cyc();
    idle(); pe_if.i_fmap = 2; pe_if.i_fmap_vld = 1; cyc();
    check("t2_prod9", 64'(pe_if.o_psum), 64'd18);
    idle(); pe_if.w_swap = 1; cyc();
    idle(); pe_if.i_fmap = 2; pe_if.i_fmap_vld = 1; cyc();
    check("t2_swap_ignored", 64'(pe_if.o_psum), 64'd18);
    // 3: local unsigned accumulate and drain
    idle(); pe_if.acc_mode = 1; pe_if.acc_clr = 1; cyc();
    load_w(8'd4);
    for (int i = 1; i <= 3; i++) begin
      idle(); pe_if.i_fmap = 8'(i); pe_if.i_fmap_vld = 1; cyc();
      check("t3_no_out", 64'(pe_if.o_psum_vld), 64'd0);
    end
    idle(); pe_if.acc_drain = 1; cyc();
    check("t3_drain", 64'(pe_if.o_psum), 64'd24);
    check("t3_vld", 64'(pe_if.o_psum_vld), 64'd1);
    idle(); cyc();
    check("t3_vld_drop", 64'(pe_if.o_psum_vld), 64'd0);
    idle(); pe_if.acc_drain = 1; cyc();
    check("t3_cleared", 64'(pe_if.o_psum), 64'd0);
    // 4: signed chain
    idle(); pe_if.acc_mode = 0; pe_if.signed_mode = 1;
    load_w(8'hFE);
    pe_if.i_fmap = 8'hFD; pe_if.i_fmap_vld = 1; pe_if.i_psum = 24'hFFFFF6; cyc();
    check("t4_psum", 64'(pe_if.o_psum), 64'hFFFFFC);
    // 5: signed local overflow, 512 x 16384 crosses +2^23
    idle(); pe_if.acc_mode = 1; pe_if.acc_clr = 1; cyc();
    load_w(8'h80);
    for (int i = 0; i < 512; i++) begin
      idle(); pe_if.i_fmap = 8'h80; pe_if.i_fmap_vld = 1; cyc();
      if (i == 510) check("t5_no_ovf_yet", 64'(pe_if.o_ovf), 64'd0);
    end
    check("t5_ovf", 64'(pe_if.o_ovf), 64'd1);
    idle(); pe_if.acc_drain = 1; cyc();
`ifdef ACC_SAT_EN
    check("t5_sat", 64'(pe_if.o_psum), 64'h7FFFFF);
`else
    check("t5_wrap", 64'(pe_if.o_psum), 64'h800000);
`endif
    idle(); cyc();
    check("t5_sticky", 64'(pe_if.o_ovf), 64'd1);
    idle(); pe_if.acc_clr = 1; cyc();
    check("t5_clr_ovf", 64'(pe_if.o_ovf), 64'd0);
    // unsigned local overflow: 259 x 65025 exceeds 2^24-1
    idle(); pe_if.signed_mode = 0;
    load_w(8'hFF);
    for (int i = 0; i < 259; i++) begin
      idle(); pe_if.i_fmap = 8'hFF; pe_if.i_fmap_vld = 1; cyc();
    end
    check("t5u_ovf", 64'(pe_if.o_ovf), 64'd1);
    idle(); pe_if.acc_drain = 1; cyc();
    // 6: hold with pe_en=0
    idle(); pe_if.acc_mode = 0; pe_if.i_fmap = 8'h11; pe_if.i_fmap_vld = 1; pe_if.i_psum = 24'h000100; cyc();
    snap = {pe_if.o_fmap, pe_if.o_fmap_vld, pe_if.o_weight, pe_if.o_weight_vld,
            pe_if.o_psum, pe_if.o_psum_vld, pe_if.o_ovf};
    for (int i = 0; i < 3; i++) begin
      pe_if.pe_en = 0; pe_if.i_fmap = 8'($urandom); pe_if.i_fmap_vld = 1;
      pe_if.i_weight = 8'($urandom); pe_if.i_weight_vld = 1; pe_if.w_swap = 1;
      pe_if.i_psum = 24'($urandom); pe_if.acc_clr = 1; pe_if.acc_drain = 1;
      cyc();
      check("t6_frozen", 64'({pe_if.o_fmap, pe_if.o_fmap_vld, pe_if.o_weight, pe_if.o_weight_vld,
                              pe_if.o_psum, pe_if.o_psum_vld, pe_if.o_ovf}), 64'(snap));
    end
    // reset mid-run drops the active weight too
    idle(); cyc();
    reset_now();
    idle(); pe_if.acc_mode = 0; pe_if.w_swap = 1; cyc();
    idle(); pe_if.i_fmap = 8'h7F; pe_if.i_fmap_vld = 1; pe_if.i_psum = 24'h000123; cyc();
    check("t6_no_active", 64'(pe_if.o_psum), 64'h000123);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        pe_if.acc_mode = 1'($urandom);
        pe_if.signed_mode = 1'($urandom);
      end
      pe_if.pe_en        = ($urandom_range(9) != 0);
      pe_if.i_fmap       = 8'($urandom);
      pe_if.i_fmap_vld   = ($urandom_range(3) != 0);
      pe_if.i_weight     = 8'($urandom);
      pe_if.i_weight_vld = ($urandom_range(4) == 0);
      pe_if.w_swap       = ($urandom_range(9) == 0);
      pe_if.i_psum       = 24'($urandom);
      pe_if.acc_clr      = ($urandom_range(29) == 0);
      pe_if.acc_drain    = ($urandom_range(19) == 0);
      if (i == 1500) reset_now();
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
